instruction_fetch_unit: RTL and testbench



---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch front end.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
  localparam int unsigned DEFAULT_PC_INCR      = 4;
  localparam logic [1:0]  ALIGN_MASK           = 2'b11;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, sequential advance, redirect load and
// redirect-target alignment check.
module fetch_pc_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned PC_INCR      = DEFAULT_PC_INCR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_seq_i,
  input  logic        load_tgt_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_plus4_o   = pc_q + 32'(PC_INCR);
  assign misaligned_o = |(target_i[1:0] & ALIGN_MASK);
  assign pc_o         = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_tgt_i)      pc_d = target_i;
    else if (load_seq_i) pc_d = pc_plus4_o;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequences req/ack fetches and holds the instruction for a stalling consumer.
// Define FETCH_COUNTER_EN to build the consumed-instruction counter on fetch_count.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned PC_INCR      = DEFAULT_PC_INCR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic         consume;
  logic         misaligned;
  logic         load_seq;
  logic         load_tgt;

  // Redirect is only honoured when the instruction is actually consumed.
  assign consume  = (state_q == VALID) && !stall;
  assign load_seq = consume && !redirect_valid;
  assign load_tgt = consume && redirect_valid && !misaligned;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_INCR      (PC_INCR)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .load_seq_i   (load_seq),
    .load_tgt_i   (load_tgt),
    .target_i     (redirect_target),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (consume) begin
          if (redirect_valid && misaligned) state_d = FAULT;
          else                              state_d = REQ;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == VALID);
  assign fetch_fault = (state_q == FAULT);
  assign instr       = instr_q;

`ifdef FETCH_COUNTER_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)        count_q <= '0;
    else if (consume) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, slow ack, stall,
// redirects, wrap, misaligned fault, reset recovery and consume counting.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    step(); step();

    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_pc",    pc,               32'h0040_0000);
    check("rst_pc4",   pc_plus4,         32'h0040_0004);
    check("rst_instr", instr,            32'h0);
    check("rst_count", fetch_count,      32'h0);

    // Sequential fetch with one-cycle ack
    reset = 1'b0;
    step();
    check("seq0_req",  32'(imem_req), 32'd1);
    check("seq0_addr", imem_addr,     32'h0040_0000);
    imem_ack = 1'b1; imem_rdata = 32'h2408_0001;
    step();
    imem_ack = 1'b0;
    check("seq0_valid", 32'(instr_valid), 32'd1);
    check("seq0_instr", instr,            32'h2408_0001);
    check("seq0_noreq", 32'(imem_req),    32'd0);
    step();
    check("seq1_addr", imem_addr,         32'h0040_0004);
    check("seq1_novl", 32'(instr_valid),  32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h2509_0002;
    step();
    imem_ack = 1'b0;
    check("seq1_instr", instr,            32'h2509_0002);
    check("seq1_valid", 32'(instr_valid), 32'd1);
    step();
    check("seq2_addr", imem_addr, 32'h0040_0008);

    // Slow memory: request and address held while ack is absent
    for (int i = 0; i < 5; i++) begin
      step();
      check("slow_req",   32'(imem_req),    32'd1);
      check("slow_addr",  imem_addr,        32'h0040_0008);
      check("slow_novl",  32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0003;
    step();
    imem_ack = 1'b0;
    check("slow_instr", instr, 32'hCAFE_0003);

    // Stall with redirect asserted: everything holds
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr,            32'hCAFE_0003);
      check("stall_pc",    pc,               32'h0040_0008);
    end
    stall = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr,     32'h0040_0100);
    check("redir_req",  32'(imem_req), 32'd1);

    // Redirect to top of address space, then wrap on sequential advance
    imem_ack = 1'b1; imem_rdata = 32'h0000_0004;
    step();
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_pc4",  pc_plus4,  32'h0000_0000);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0005;
    step();
    imem_ack = 1'b0;
    step();
    check("wrap_addr",  imem_addr,        32'h0000_0000);
    check("wrap_fault", 32'(fetch_fault), 32'd0);

    // Misaligned redirect faults permanently
    imem_ack = 1'b1; imem_rdata = 32'h0000_0006;
    step();
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
    step();
    redirect_valid = 1'b0;
    check("flt_fault", 32'(fetch_fault), 32'd1);
    check("flt_req",   32'(imem_req),    32'd0);
    check("flt_pc",    pc,               32'h0000_0000);
    imem_ack = 1'b1;
    step(); step();
    check("flt_hold",   32'(fetch_fault), 32'd1);
    check("flt_holdrq", 32'(imem_req),    32'd0);
    check("flt_novl",   32'(instr_valid), 32'd0);

    // Reset clears fault; stale ack in IDLE is ignored
    reset = 1'b1;
    step();
    check("rcv_fault", 32'(fetch_fault), 32'd0);
    check("rcv_pc",    pc,               32'h0040_0000);
    reset = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    step();
    check("stale_req",   32'(imem_req),    32'd1);
    check("stale_novl",  32'(instr_valid), 32'd0);
    check("stale_addr",  imem_addr,        32'h0040_0000);
    check("stale_instr", instr,            32'h0);
    imem_rdata = 32'h1111_0007;
    step();
    imem_ack = 1'b0;
    check("post_instr", instr, 32'h1111_0007);
    step();
    check("post_addr", imem_addr, 32'h0040_0004);

    // Reset while a request is outstanding
    reset = 1'b1; imem_ack = 1'b1;
    step();
    check("mid_req",   32'(imem_req),    32'd0);
    check("mid_valid", 32'(instr_valid), 32'd0);
    check("mid_pc",    pc,               32'h0040_0000);
    step();
    reset = 1'b0;
    step();
    check("mid_first", imem_addr, 32'h0040_0000);
    check("mid_rqhi",  32'(imem_req), 32'd1);

    // Ten consumes from a fresh reset
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'(i);
      step();
      imem_ack = 1'b0;
      check("cnt_instr", instr, 32'(i));
      step();
    end
    check("cnt_addr", imem_addr, 32'h0040_0028);
`ifdef FETCH_COUNTER_EN
    check("cnt_value", fetch_count, 32'd10);
`else
    check("cnt_value", fetch_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
